sw_btn_event_gen: RTL

- Front-end input conditioner for the password-lock system controller. It sits between the board pins (SW[9:0], BTN[3:0]) and the lock FSM.
- Debounces all 14 inputs and tracks the debounced switch levels.
- Turns each debounced switch change into a queued event carrying the switch index and direction (up/down), delivered over a valid/ready handshake.
- Emits one-cycle pulses on debounced button rising edges (RESET, ADMIN, OK, BACKSPACE).

---
 rtl/lock_pkg.sv | 17 +
 rtl/debounce_bit.sv | 52 +++++
 rtl/sw_btn_event_gen.sv | 127 ++++++++++++
 3 files changed

// File: rtl/lock_pkg.sv
// Shared constants for the password-lock front end: button indices, input counts
// and the default debounce interval.
package lock_pkg;

  localparam int unsigned NUM_SW   = 10;
  localparam int unsigned NUM_BTN  = 4;
  localparam int unsigned SW_IDX_W = 4;

  // 10 ms at 100 MHz.
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1000000;

  localparam int unsigned BTN_RESET     = 0;
  localparam int unsigned BTN_ADMIN     = 1;
  localparam int unsigned BTN_OK        = 2;
  localparam int unsigned BTN_BACKSPACE = 3;

endpackage

// File: rtl/debounce_bit.sv
// Single-bit counter debouncer. The level flips once the raw input has differed from it
// for Cycles consecutive clocks; rise_o/fall_o strobe in the cycle just before the flip.
module debounce_bit #(
  parameter int unsigned Cycles = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  input  logic init_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CntW = $clog2(Cycles);
  localparam logic [CntW-1:0] CntMax = CntW'(Cycles - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            flip;

  // Count consecutive mismatches; the flip at CntMax keeps the counter from wrapping.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    flip    = (raw_i != level_q) && (cnt_q == CntMax);
    if (raw_i == level_q) begin
      cnt_d = '0;
    end else if (flip) begin
      cnt_d   = '0;
      level_d = ~level_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Level and counter state; level reloads from init_i so reset never creates an edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      level_q <= init_i;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = flip & ~level_q;
  assign fall_o  = flip & level_q;

endmodule

// File: rtl/sw_btn_event_gen.sv
// Input conditioner for the lock controller: debounces switches and buttons, queues
// switch edge events behind a valid/ready handshake and pulses on button presses.
// Define SW_BTN_INPUT_SYNC_EN to add a 2-flop synchroniser ahead of every debouncer.
module sw_btn_event_gen
  import lock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [NUM_SW-1:0]   SW,
  input  logic [NUM_BTN-1:0]  BTN,
  output logic [NUM_SW-1:0]   SW_LEVEL,
  output logic                SW_EVT_VALID,
  output logic [SW_IDX_W-1:0] SW_EVT_IDX,
  output logic                SW_EVT_UP,
  input  logic                SW_EVT_READY,
  output logic [NUM_BTN-1:0]  BTN_PULSE,
  output logic [NUM_BTN-1:0]  BTN_LEVEL
);

  logic [NUM_SW-1:0]  sw_raw, sw_rise, sw_fall;
  logic [NUM_BTN-1:0] btn_raw, btn_rise, unused_btn_fall;
  logic [NUM_SW-1:0]  pend_q, pend_d, pend_up_q, pend_up_d;
  logic [NUM_BTN-1:0] btn_pulse_q;
  logic               accept;

`ifdef SW_BTN_INPUT_SYNC_EN
  logic [NUM_SW-1:0]  sw_meta_q, sw_sync_q;
  logic [NUM_BTN-1:0] btn_meta_q, btn_sync_q;

  // Two-flop synchronisers; switch flops load the pins so reset produces no edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sw_meta_q  <= SW;
      sw_sync_q  <= SW;
      btn_meta_q <= '0;
      btn_sync_q <= '0;
    end else begin
      sw_meta_q  <= SW;
      sw_sync_q  <= sw_meta_q;
      btn_meta_q <= BTN;
      btn_sync_q <= btn_meta_q;
    end
  end

  assign sw_raw  = sw_sync_q;
  assign btn_raw = btn_sync_q;
`else
  assign sw_raw  = SW;
  assign btn_raw = BTN;
`endif

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw_db
    debounce_bit #(
      .Cycles (DEBOUNCE_CYCLES)
    ) u_db (
      .clk_i   (CLK),
      .rst_i   (RESET),
      .raw_i   (sw_raw[i]),
      .init_i  (SW[i]),
      .level_o (SW_LEVEL[i]),
      .rise_o  (sw_rise[i]),
      .fall_o  (sw_fall[i])
    );
  end

  for (genvar k = 0; k < NUM_BTN; k++) begin : g_btn_db
    debounce_bit #(
      .Cycles (DEBOUNCE_CYCLES)
    ) u_db (
      .clk_i   (CLK),
      .rst_i   (RESET),
      .raw_i   (btn_raw[k]),
      .init_i  (1'b0),
      .level_o (BTN_LEVEL[k]),
      .rise_o  (btn_rise[k]),
      .fall_o  (unused_btn_fall[k])
    );
  end

  // Fixed-priority presentation: lowest pending index wins.
  always_comb begin
    SW_EVT_IDX = '0;
    for (int i = NUM_SW - 1; i >= 0; i--) begin
      if (pend_q[i]) SW_EVT_IDX = SW_IDX_W'(i);
    end
  end

  assign SW_EVT_VALID = |pend_q;
  assign SW_EVT_UP    = pend_up_q[SW_EVT_IDX];
  assign accept       = SW_EVT_VALID && SW_EVT_READY;

  // Pending-event update: accept clears the presented bit, a fresh edge on an already
  // pending switch cancels it, and an edge coinciding with its own accept re-arms it.
  always_comb begin
    pend_d    = pend_q;
    pend_up_d = pend_up_q;
    if (accept) pend_d[SW_EVT_IDX] = 1'b0;
    for (int i = 0; i < NUM_SW; i++) begin
      if (sw_rise[i] || sw_fall[i]) begin
        if (pend_q[i] && !(accept && (SW_EVT_IDX == SW_IDX_W'(i)))) begin
          pend_d[i] = 1'b0;
        end else begin
          pend_d[i]    = 1'b1;
          pend_up_d[i] = sw_rise[i];
        end
      end
    end
  end

  // Event queue and button pulse registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend_q      <= '0;
      pend_up_q   <= '0;
      btn_pulse_q <= '0;
    end else begin
      pend_q      <= pend_d;
      pend_up_q   <= pend_up_d;
      btn_pulse_q <= btn_rise;
    end
  end

  assign BTN_PULSE = btn_pulse_q;

endmodule
